// File: rtl/fb_pkg.sv
// Shared constants and response tag type for the frame buffer read path.
// Geometry is fixed at 320x240 with one 16-bit pixel per word.
package fb_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 16;

    typedef struct packed {
        logic valid;
        logic id;
        logic oob;
    } resp_tag_t;

endpackage

// File: rtl/fb_resp_pipe.sv
// Tag delay line matching the frame buffer read latency.
// The tail carries the owner of the data present on mem_rdata.
module fb_resp_pipe
    import fb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  resp_tag_t tag_in,
    output resp_tag_t tag_out
);

    resp_tag_t stage [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Two-requester arbiter for the frame buffer read port with urgent boost,
// starvation guard for the window fetcher and zero-data out-of-range reads.
module fb_read_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W   = fb_pkg::ADDR_W,
    parameter int DATA_W   = fb_pkg::DATA_W,
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              urgent0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FB_DEPTH);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              last_gnt;
    logic              forced;
    logic              pick0;
    logic              pick1;
    logic              any_gnt;
    logic              oob;
    logic [ADDR_W-1:0] sel_addr;
    resp_tag_t         tag_in;
    resp_tag_t         tag_out;

    assign forced = req1 && (wait_cnt == WAIT_MAX);

    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (!reset) begin
            if (forced) begin
                pick1 = 1'b1;
            end else if (urgent0 && req0) begin
                pick0 = 1'b1;
            end else if (req0 && req1) begin
                pick0 = last_gnt;
                pick1 = !last_gnt;
            end else begin
                pick0 = req0;
                pick1 = req1;
            end
        end
    end

    assign gnt0    = pick0;
    assign gnt1    = pick1;
    assign any_gnt = pick0 || pick1;

    // Unsigned compare also catches wrapped negative window offsets.
    assign sel_addr = pick1 ? addr1 : addr0;
    assign oob      = sel_addr >= LIMIT;
    assign mem_en   = any_gnt && !oob;
    assign mem_addr = mem_en ? sel_addr : '0;

    always_comb begin
        wait_nxt = '0;
        if (req1 && !pick1) begin
            wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt
                                              : wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            last_gnt <= 1'b1;
        end else begin
            wait_cnt <= wait_nxt;
            if (any_gnt) begin
                last_gnt <= pick1;
            end
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = any_gnt;
        tag_in.id    = pick1;
        tag_in.oob   = any_gnt && oob;
    end

    fb_resp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign rvalid0 = tag_out.valid && !tag_out.id;
    assign rvalid1 = tag_out.valid && tag_out.id;
    assign rdata0  = (rvalid0 && !tag_out.oob) ? mem_rdata : '0;
    assign rdata1  = (rvalid1 && !tag_out.oob) ? mem_rdata : '0;

    a_one_hot: assert property (@(posedge clk) disable iff (reset)
        !(gnt0 && gnt1));

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Randomized and directed bench for fb_read_arbiter at RD_LAT 1 and 3,
// checked against a rule-level arbitration model with response queues.
module tb_fb_read_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 16;
    localparam int DEPTH = 76800;
    localparam int MW    = 8;

    typedef struct {
        int          due;
        bit          id;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, urgent0, req1;
    logic [AW-1:0] addr0, addr1;

    logic          gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_en_a;
    logic [DW-1:0] rdata0_a, rdata1_a, mem_rdata_a;
    logic [AW-1:0] mem_addr_a;
    logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_en_b;
    logic [DW-1:0] rdata0_b, rdata1_b, mem_rdata_b;
    logic [AW-1:0] mem_addr_b;

    logic [DW-1:0] rd_b [3];

    int   errs   = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   wcnt;
    int   last;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    fb_read_arbiter #(.RD_LAT(1), .MAX_WAIT(MW)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .urgent0(urgent0),
        .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
        .req1(req1), .addr1(addr1),
        .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a),
        .mem_rdata(mem_rdata_a)
    );

    fb_read_arbiter #(.RD_LAT(3), .MAX_WAIT(MW)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .urgent0(urgent0),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
        .req1(req1), .addr1(addr1),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b),
        .mem_rdata(mem_rdata_b)
    );

    function automatic logic [15:0] ram(input logic [16:0] a);
        return (a[15:0] ^ 16'h5A5A) + {15'd0, a[16]} + 16'd1;
    endfunction

    // Memory stand-ins; unread cycles return junk that must never leak.
    always @(posedge clk) begin
        mem_rdata_a <= mem_en_a ? ram(mem_addr_a) : 16'hDEAD;
        rd_b[0]     <= mem_en_b ? ram(mem_addr_b) : 16'hBEEF;
        rd_b[1]     <= rd_b[0];
        rd_b[2]     <= rd_b[1];
    end
    assign mem_rdata_b = rd_b[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_resp(input string t, input bit have, input exp_t x,
                            input logic v0, input logic v1,
                            input logic [15:0] d0, input logic [15:0] d1);
        chk({t, ".rvalid0"}, v0, have && !x.id);
        chk({t, ".rvalid1"}, v1, have && x.id);
        chk({t, ".rdata0"}, d0, (have && !x.id) ? x.data : 16'h0);
        chk({t, ".rdata1"}, d1, (have && x.id) ? x.data : 16'h0);
    endtask

    task automatic model_step();
        bit          e0, e1, oob, ha, hb;
        logic [16:0] ga;
        exp_t        xa, xb, n;
        xa = '{due: 0, id: 1'b0, data: 16'h0};
        xb = xa;
        if (reset) begin
            chk("rst.gnt0", gnt0_a | gnt0_b, 0);
            chk("rst.gnt1", gnt1_a | gnt1_b, 0);
            chk("rst.mem_en", mem_en_a | mem_en_b, 0);
            chk("rst.mem_addr", mem_addr_a | mem_addr_b, 0);
            chk_resp("rst.a", 0, xa, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a);
            chk_resp("rst.b", 0, xb, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b);
            wcnt = 0;
            last = 1;
            qa.delete();
            qb.delete();
        end else begin
            e0 = 0;
            e1 = 0;
            if (req1 && wcnt == MW) e1 = 1;
            else if (urgent0 && req0) e0 = 1;
            else if (req0 && req1) begin
                if (last == 1) e0 = 1;
                else e1 = 1;
            end else if (req0) e0 = 1;
            else if (req1) e1 = 1;
            ga  = e1 ? addr1 : addr0;
            oob = int'(ga) >= DEPTH;
            chk("a.gnt0", gnt0_a, e0);
            chk("a.gnt1", gnt1_a, e1);
            chk("b.gnt0", gnt0_b, e0);
            chk("b.gnt1", gnt1_b, e1);
            chk("a.mem_en", mem_en_a, (e0 | e1) && !oob);
            chk("b.mem_en", mem_en_b, (e0 | e1) && !oob);
            chk("a.mem_addr", mem_addr_a, ((e0 | e1) && !oob) ? ga : 17'd0);
            chk("b.mem_addr", mem_addr_b, ((e0 | e1) && !oob) ? ga : 17'd0);
            ha = 0;
            hb = 0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                xa = qa.pop_front();
                ha = 1;
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                xb = qb.pop_front();
                hb = 1;
            end
            chk_resp("a", ha, xa, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a);
            chk_resp("b", hb, xb, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b);
            if (e0 || e1) begin
                last = e1 ? 1 : 0;
                n = '{due: cyc + 1, id: e1, data: oob ? 16'h0 : ram(ga)};
                qa.push_back(n);
                n.due = cyc + 3;
                qb.push_back(n);
            end
            if (req1 && !e1) wcnt = (wcnt < MW) ? wcnt + 1 : MW;
            else wcnt = 0;
        end
        cyc++;
    endtask

    task automatic tick(input bit rst, input bit r0, input int a0,
                        input bit u0, input bit r1, input int a1);
        @(negedge clk);
        reset   = rst;
        req0    = r0;
        addr0   = AW'(a0);
        urgent0 = u0;
        req1    = r1;
        addr1   = AW'(a1);
        #3;
        model_step();
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 5))
            0: return DEPTH - 1;
            1: return DEPTH;
            2: return 32'h1FFFF - $urandom_range(0, 320);
            3: return $urandom_range(0, 400);
            default: return $urandom_range(0, 32'h1FFFF);
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        req0    = 1'b0;
        urgent0 = 1'b0;
        req1    = 1'b0;
        addr0   = '0;
        addr1   = '0;
        wcnt    = 0;
        last    = 1;

        for (int i = 0; i < 3; i++) tick(1, 1, 5, 1, 1, 7);
        tick(0, 0, 0, 0, 1, 100);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);

        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 200 + i, 0, 1, 300 + i);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) tick(0, 1, 400 + i, 1, 1, 500 + i);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);

        tick(0, 0, 0, 0, 1, 32'h1FFFF);
        tick(0, 1, DEPTH, 0, 0, 0);
        tick(0, 1, DEPTH - 1, 0, 1, DEPTH);
        tick(0, 1, DEPTH - 1, 0, 1, DEPTH);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);

        tick(0, 1, 10, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 20);
        tick(0, 1, 30, 0, 1, 40);
        tick(0, 1, 50, 1, 1, 60);
        tick(0, 0, 0, 0, 1, 70);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);

        tick(0, 1, 1000, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 1, 3, 0, 1, 4);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 2000, 0, 1, 2001);
        tick(0, 1, 2002, 0, 1, 2003);

        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0, rand_addr(),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, rand_addr());
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
